// File: rtl/edge_pkg.sv
// Shared definitions for the sliding-window line buffer: width helper,
// edge-handling encodings and the fill/run state type.
package edge_pkg;

   localparam int EDGE_ALL      = 0;
   localparam int EDGE_SUPPRESS = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } wlb_state_t;

   // Counter width for a range of n values; never narrower than one bit.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/window_line_buffer_line_delay.sv
// Single-clock word delay: shared read/write address, read-before-write, so a
// word written now reappears on rdata after DEPTH pointer advances.
module line_delay #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 76,
   parameter int AW     = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/window_line_buffer.sv
// Sliding WIN_ROWS x WIN_COLS window over a raster word stream, with
// valid/ready flow control, frame-start resync and line-wrap suppression.
//
//   state | meaning
//   IDLE  | no frame seen yet; words are handshaken and discarded
//   FILL  | frame started, not enough lines/columns for a full window
//   RUN   | window rows are populated; accepted words produce windows
module window_line_buffer
   import edge_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 78,
   parameter int WIN_ROWS   = 3,
   parameter int WIN_COLS   = 2,
   parameter int EDGE_MODE  = EDGE_SUPPRESS
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                in_sof,
   input  logic [DATA_W-1:0]                   in_data,
   output logic                                win_valid,
   input  logic                                win_ready,
   output logic [WIN_ROWS*WIN_COLS*DATA_W-1:0] win_data,
   output logic [width_of(LINE_WORDS)-1:0]     win_col,
   output logic                                win_sol
);

   localparam int CW    = width_of(LINE_WORDS);
   localparam int LW    = width_of(WIN_ROWS);
   localparam int DEPTH = LINE_WORDS - WIN_COLS;
   localparam int WIN_W = WIN_ROWS * WIN_COLS * DATA_W;

   localparam logic [CW-1:0] COL_LAST  = CW'(LINE_WORDS - 1);
   localparam logic [CW-1:0] COL_SOL   = CW'(WIN_COLS - 1);
   localparam logic [CW-1:0] PTR_LAST  = CW'(DEPTH - 1);
   localparam logic [LW-1:0] LINE_FULL = LW'(WIN_ROWS - 1);

   wlb_state_t        state;
   logic [CW-1:0]     col;
   logic [CW-1:0]     ptr;
   logic [LW-1:0]     line_cnt;
   logic              accept;
   logic              win_load;
   logic [DATA_W-1:0] taps      [WIN_ROWS][WIN_COLS];
   logic [DATA_W-1:0] next_taps [WIN_ROWS][WIN_COLS];
   logic [DATA_W-1:0] rd        [WIN_ROWS-1];
   logic [WIN_W-1:0]  next_flat;

   // rst_n gates ready directly so nothing is handshaken while reset is held.
   assign in_ready = rst_n & (~win_valid | win_ready);
   assign accept   = in_valid & in_ready;

   // Each line delay feeds the row above it with the word evicted from the
   // oldest tap of the row below, giving exactly one line of total delay.
   for (genvar r = 0; r < WIN_ROWS - 1; r++) begin : g_delay
      line_delay #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .AW     (CW)
      ) u_line_delay (
         .clk   (clk),
         .we    (accept),
         .addr  (ptr),
         .wdata (taps[r+1][0]),
         .rdata (rd[r])
      );
   end

   always_comb begin
      for (int r = 0; r < WIN_ROWS; r++) begin
         for (int c = 0; c < WIN_COLS - 1; c++) begin
            next_taps[r][c] = taps[r][c+1];
         end
      end
      for (int r = 0; r < WIN_ROWS - 1; r++) begin
         next_taps[r][WIN_COLS-1] = rd[r];
      end
      next_taps[WIN_ROWS-1][WIN_COLS-1] = in_data;
   end

   always_comb begin
      next_flat = '0;
      for (int r = 0; r < WIN_ROWS; r++) begin
         for (int c = 0; c < WIN_COLS; c++) begin
            next_flat[(r*WIN_COLS + c)*DATA_W +: DATA_W] = next_taps[r][c];
         end
      end
   end

   // A frame-start word is column 0 of a fresh frame and never completes a window.
   always_comb begin
      win_load = 1'b0;
      if (accept && !in_sof) begin
         case (state)
            FILL:    win_load = (line_cnt == LINE_FULL) && (col >= COL_SOL);
            RUN:     win_load = !((EDGE_MODE == EDGE_SUPPRESS) && (col < COL_SOL));
            default: win_load = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         col      <= '0;
         line_cnt <= '0;
      end else if (accept) begin
         if (in_sof) begin
            state    <= FILL;
            col      <= CW'(1);
            line_cnt <= '0;
         end else if (state != IDLE) begin
            col <= (col == COL_LAST) ? '0 : col + 1'b1;
            if (col == COL_LAST && line_cnt != LINE_FULL) line_cnt <= line_cnt + 1'b1;
            if (state == FILL && win_load) state <= RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < WIN_ROWS; r++) begin
            for (int c = 0; c < WIN_COLS; c++) begin
               taps[r][c] <= '0;
            end
         end
         ptr       <= '0;
         win_valid <= 1'b0;
         win_data  <= '0;
         win_col   <= '0;
         win_sol   <= 1'b0;
      end else begin
         if (accept) begin
            taps <= next_taps;
            ptr  <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
         end
         if (win_load) begin
            win_valid <= 1'b1;
            win_data  <= next_flat;
            win_col   <= col;
            win_sol   <= (col == COL_SOL);
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench: two instances (index = EDGE_MODE) driven in turn; a raster
// reference model predicts windows from word positions within the frame.
module tb_window_line_buffer;

   localparam int W  = 8;
   localparam int L  = 8;
   localparam int R  = 3;
   localparam int C  = 2;
   localparam int EW = R * C * W;

   typedef struct {
      logic [EW-1:0] d;
      logic [2:0]    col;
      logic          sol;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid  [2];
   logic          in_ready  [2];
   logic          in_sof    [2];
   logic [W-1:0]  in_data   [2];
   logic          win_valid [2];
   logic          win_ready [2];
   logic [EW-1:0] win_data  [2];
   logic [2:0]    win_col   [2];
   logic          win_sol   [2];

   exp_t          sbq  [2][$];
   logic [W-1:0]  hist [2][$];
   bit            in_frame [2];
   int            n_checks;
   int            n_fail;
   int            n_win [2];
   int            k;
   int            p;
   exp_t          ne;
   exp_t          mon_e;
   logic [EW-1:0] saved;

   window_line_buffer #(
      .DATA_W(W), .LINE_WORDS(L), .WIN_ROWS(R), .WIN_COLS(C), .EDGE_MODE(0)
   ) u_all (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sof(in_sof[0]), .in_data(in_data[0]),
      .win_valid(win_valid[0]), .win_ready(win_ready[0]), .win_data(win_data[0]),
      .win_col(win_col[0]), .win_sol(win_sol[0])
   );

   window_line_buffer #(
      .DATA_W(W), .LINE_WORDS(L), .WIN_ROWS(R), .WIN_COLS(C), .EDGE_MODE(1)
   ) u_sup (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sof(in_sof[1]), .in_data(in_data[1]),
      .win_valid(win_valid[1]), .win_ready(win_ready[1]), .win_data(win_data[1]),
      .win_col(win_col[1]), .win_sol(win_sol[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [EW-1:0] win6(input int e0, input int e1, input int e2,
                                          input int e3, input int e4, input int e5);
      logic [EW-1:0] f;
      f = {8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
      return f;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus; the word counter advances only if the word was taken.
   task automatic cycle(input int m, input bit v, input bit sof, input bit wr);
      bit acc;
      in_valid[m]  = v;
      in_sof[m]    = sof;
      in_data[m]   = 8'(k);
      win_ready[m] = wr;
      @(negedge clk);
      acc = v && in_ready[m];
      @(posedge clk);
      #1;
      if (acc) k++;
      in_valid[m] = 1'b0;
      in_sof[m]   = 1'b0;
   endtask

   // Reference model: a window exists for frame position p once R-1 full lines
   // and C-1 further words are in; element (r,c) is the word (R-1-r) lines and
   // (C-1-c) words earlier in the frame.
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            in_frame[m] = 1'b0;
            sbq[m].delete();
            hist[m].delete();
         end else if (in_valid[m] && in_ready[m]) begin
            if (in_sof[m]) begin
               in_frame[m] = 1'b1;
               hist[m].delete();
            end
            if (in_frame[m]) begin
               hist[m].push_back(in_data[m]);
               p = hist[m].size() - 1;
               if (p >= (R-1)*L + C-1 && (m == 0 || (p % L) >= C-1)) begin
                  ne.d = '0;
                  for (int r = 0; r < R; r++) begin
                     for (int c = 0; c < C; c++) begin
                        ne.d[(r*C + c)*W +: W] = hist[m][p - (R-1-r)*L - (C-1-c)];
                     end
                  end
                  ne.col = 3'(p % L);
                  ne.sol = ((p % L) == C-1);
                  sbq[m].push_back(ne);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst_n && win_valid[m] && win_ready[m]) begin
            n_checks++;
            if (sbq[m].size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_window dut%0d: got col %0d data %0h, required no window",
                        m, win_col[m], win_data[m]);
            end else begin
               mon_e = sbq[m].pop_front();
               n_win[m]++;
               if (win_data[m] !== mon_e.d || win_col[m] !== mon_e.col || win_sol[m] !== mon_e.sol) begin
                  n_fail++;
                  $display("FAIL window dut%0d: got data %0h col %0d sol %0b, required data %0h col %0d sol %0b",
                           m, win_data[m], win_col[m], win_sol[m], mon_e.d, mon_e.col, mon_e.sol);
               end
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_win[0] = 0;
      n_win[1] = 0;
      k        = 0;
      rst_n    = 1'b0;
      for (int m = 0; m < 2; m++) begin
         in_valid[m]  = 1'b0;
         in_sof[m]    = 1'b0;
         in_data[m]   = '0;
         win_ready[m] = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready[1]), 64'd0);
      chk("reset_win_valid", 64'(win_valid[1]), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("release_in_ready", 64'(in_ready[1]), 64'd1);

      // EDGE_MODE=0: fill then wrap window straddling the line boundary
      k = 0;
      for (int i = 0; i <= 24; i++) begin
         cycle(0, 1'b1, i == 0, 1'b1);
         if (i == 16) chk("m0_fill_none", 64'(win_valid[0]), 64'd0);
         if (i == 17) chk("m0_first_data", 64'(win_data[0]), 64'(win6(0, 1, 8, 9, 16, 17)));
      end
      chk("m0_wrap_data", 64'(win_data[0]), 64'(win6(7, 8, 15, 16, 23, 24)));
      chk("m0_wrap_col", 64'(win_col[0]), 64'd0);
      chk("m0_wrap_sol", 64'(win_sol[0]), 64'd0);
      for (int i = 0; i < 100; i++)
         cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0);
      for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b0, 1'b1);

      // EDGE_MODE=1: fill, suppressed wrap, first window of next line
      k = 0;
      for (int i = 0; i <= 25; i++) begin
         cycle(1, 1'b1, i == 0, 1'b1);
         if (i == 16) chk("m1_fill_none", 64'(win_valid[1]), 64'd0);
         if (i == 17) begin
            chk("m1_first_data", 64'(win_data[1]), 64'(win6(0, 1, 8, 9, 16, 17)));
            chk("m1_first_col", 64'(win_col[1]), 64'd1);
            chk("m1_first_sol", 64'(win_sol[1]), 64'd1);
         end
         if (i == 24) chk("m1_wrap_none", 64'(win_valid[1]), 64'd0);
      end
      chk("m1_sol_data", 64'(win_data[1]), 64'(win6(8, 9, 16, 17, 24, 25)));
      chk("m1_sol_flag", 64'(win_sol[1]), 64'd1);

      // backpressure: window from word 26 held for three cycles
      cycle(1, 1'b1, 1'b0, 1'b1);
      saved = win_data[1];
      chk("stall_valid", 64'(win_valid[1]), 64'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1'b1, 1'b0, 1'b0);
         chk("stall_in_ready", 64'(in_ready[1]), 64'd0);
         chk("stall_hold", 64'(win_data[1]), 64'(saved));
      end
      cycle(1, 1'b1, 1'b0, 1'b1);
      chk("release_col", 64'(win_col[1]), 64'd3);
      cycle(1, 1'b1, 1'b0, 1'b1);
      cycle(1, 1'b1, 1'b0, 1'b1);

      // resync at word 30
      for (int i = 30; i <= 47; i++) begin
         cycle(1, 1'b1, i == 30, 1'b1);
         if (i == 46) chk("resync_none", 64'(win_valid[1]), 64'd0);
      end
      chk("resync_data", 64'(win_data[1]), 64'(win6(30, 31, 38, 39, 46, 47)));

      for (int i = 0; i < 200; i++)
         cycle(1, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0);

      // reset between edges with a window pending
      for (int i = 0; i < 18; i++) cycle(1, 1'b1, i == 0, 1'b1);
      chk("pre_reset_valid", 64'(win_valid[1]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", 64'(win_valid[1]), 64'd0);
      chk("async_reset_data", 64'(win_data[1]), 64'd0);
      chk("async_reset_ready", 64'(in_ready[1]), 64'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) cycle(1, $urandom_range(0, 3) != 0, 1'b0, 1'b1);
      chk("no_sof_no_window", 64'(win_valid[1]), 64'd0);

      for (int i = 0; i < 4; i++) begin
         cycle(0, 1'b0, 1'b0, 1'b1);
         cycle(1, 1'b0, 1'b0, 1'b1);
      end
      chk("m0_queue_drained", 64'(sbq[0].size()), 64'd0);
      chk("m1_queue_drained", 64'(sbq[1].size()), 64'd0);
      chk("m0_windows_seen", 64'(n_win[0] > 20), 64'd1);
      chk("m1_windows_seen", 64'(n_win[1] > 20), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
